// File: rtl/vram_arb_pkg.sv
// Shared types and default geometry for the VRAM scan arbiter.
//   pixel_t     : RGB 4:4:4 pixel word
//   arb_state_t : arbiter FSM states (RUN, CLEAR)
//   COLS/ROWS/DEPTH : framebuffer geometry for the default 640x480 / SCALE 4 timing
package vram_arb_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_SCALE    = 4;
  localparam int DEF_PIX_W    = 12;
  localparam int DEF_ADDR_W   = 15;

  localparam int COLS  = DEF_H_ACTIVE / DEF_SCALE;
  localparam int ROWS  = DEF_V_ACTIVE / DEF_SCALE;
  localparam int DEPTH = COLS * ROWS;

  typedef logic [DEF_PIX_W-1:0] pixel_t;
  typedef enum logic {RUN, CLEAR} arb_state_t;
endpackage

// File: rtl/vram_scan_addr.sv
// Scanout slot decoder (purely combinational).
//   hcount, vcount : raster position from vga_timing
//   disp_read      : this cycle is the scanout read slot and the fetched pixel is visible
//   pix_ld         : cycle after a scanout read; pix_q captures mem_rdata at its end
//   fetch_addr     : framebuffer address of the pixel group being fetched
module vram_scan_addr #(
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int SCALE    = 4,
  parameter int COLS     = 160,
  parameter int ADDR_W   = 15
) (
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic              disp_read,
  output logic              pix_ld,
  output logic [ADDR_W-1:0] fetch_addr
);
  localparam int SH     = $clog2(SCALE);
  localparam int GROUPS = H_TOTAL / SCALE;

  logic [SH-1:0] phase;
  logic [10:0]   col_nx, col, line;
  logic          wrap, in_win;

  // Both the read slot (p=SCALE-2) and the load cycle (p=SCALE-1) belong to the
  // group that starts at the next multiple of SCALE, so the fetched column is
  // always group+1. Sharing it keeps the load enable aligned with the read.
  assign phase  = hcount[SH-1:0];
  assign col_nx = 11'(hcount >> SH) + 11'd1;
  assign wrap   = (col_nx == 11'(GROUPS));
  assign col    = wrap ? 11'd0 : col_nx;
  // Fetch at the end of a line prefetches column 0 of the following line.
  assign line   = !wrap ? {1'b0, vcount} :
                  (vcount == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, vcount} + 11'd1;
  assign in_win = (col < 11'(COLS)) && (line < 11'(V_ACTIVE));

  assign disp_read  = in_win && (phase == SH'(SCALE - 2));
  assign pix_ld     = in_win && (phase == SH'(SCALE - 1));
  assign fetch_addr = ADDR_W'(((32'(line) >> SH) * 32'(COLS)) + 32'(col));
endmodule

// File: rtl/vram_scan_arbiter.sv
// Shares one single-port pixel RAM (1-cycle read latency) between VGA scanout,
// a hardware clear engine and a host writer. Scanout owns one slot per SCALE
// pixels; the remaining slots go to clear, then host writes.
// Optional feature: define VRAM_ARB_DBUF_EN for double buffering (front/back
// swap at the start of vertical blank).
// Ports:
//   clk, rst (sync, active-low)
//   hcount, vcount, vga_active       : raster position from vga_timing
//   wr_valid/wr_ready/wr_addr/wr_data: host write handshake
//   clear_req, clear_color, busy     : whole-buffer fill
//   swap_req, front_buf              : buffer swap request / displayed buffer
//   mem_addr, mem_we, mem_wdata, mem_rdata : RAM port (addr MSB = buffer select)
//   pix_out                          : pixel to vga_pixel_gen, 0 outside active video
module vram_scan_arbiter
  import vram_arb_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int SCALE    = DEF_SCALE,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              vga_active,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              busy,
  input  logic              swap_req,
  output logic              front_buf,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_out
);
  localparam int N_COLS  = H_ACTIVE / SCALE;
  localparam int N_ROWS  = V_ACTIVE / SCALE;
  localparam int N_DEPTH = N_COLS * N_ROWS;

  arb_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              busy_q;
  logic [PIX_W-1:0]  pix_q;
  logic              front_q, back_sel;
  logic              disp_read, pix_ld;
  logic [ADDR_W-1:0] fetch_addr;
  logic              clr_wr, host_ok, host_wr;

  vram_scan_addr #(
    .H_TOTAL (H_TOTAL),
    .V_ACTIVE(V_ACTIVE),
    .V_TOTAL (V_TOTAL),
    .SCALE   (SCALE),
    .COLS    (N_COLS),
    .ADDR_W  (ADDR_W)
  ) u_scan (
    .hcount    (hcount),
    .vcount    (vcount),
    .disp_read (disp_read),
    .pix_ld    (pix_ld),
    .fetch_addr(fetch_addr)
  );

`ifdef VRAM_ARB_DBUF_EN
  logic swap_pending;

  // A swap only takes effect at the first pixel of vertical blank so the
  // displayed frame never tears; a request arriving on that cycle is absorbed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      front_q      <= 1'b0;
      swap_pending <= 1'b0;
    end else if (swap_pending && hcount == 10'd0 && vcount == 10'(V_ACTIVE)) begin
      front_q      <= ~front_q;
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end
  assign back_sel = ~front_q;
`else
  logic unused_swap;
  assign unused_swap = swap_req;
  assign front_q     = 1'b0;
  assign back_sel    = 1'b0;
`endif

  // Slot owners: scanout > clear > host. clear_req also blocks the host for
  // that cycle so an accepted handshake always means a real write.
  assign clr_wr   = rst && (state == CLEAR) && !disp_read;
  assign host_ok  = rst && (state == RUN) && !disp_read && !clear_req;
  assign host_wr  = host_ok && wr_valid;
  assign wr_ready = host_ok;

  always_comb begin
    mem_addr  = {front_q, fetch_addr};
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (clr_wr) begin
      mem_we    = 1'b1;
      mem_addr  = {back_sel, clr_cnt};
      mem_wdata = clear_color;
    end else if (host_wr) begin
      mem_we    = 1'b1;
      mem_addr  = {back_sel, wr_addr};
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      clr_cnt <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        RUN: if (clear_req) begin
          state   <= CLEAR;
          clr_cnt <= '0;
          busy_q  <= 1'b1;
        end
        CLEAR: if (!disp_read) begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(N_DEPTH - 1)) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Captured once per group so the replicated pixel is stable for SCALE clocks.
  always_ff @(posedge clk) begin
    if (!rst)        pix_q <= '0;
    else if (pix_ld) pix_q <= mem_rdata;
  end

  assign busy      = busy_q;
  assign front_buf = front_q;
  assign pix_out   = vga_active ? pix_q : '0;
endmodule
